// File: rtl/aes_shares_loader_pkg.sv
// rtl/aes_shares_loader_pkg.sv - shared constants, FSM states and sizing helpers for the shares loader
package aes_shares_loader_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_SHARE = 4;
    localparam int unsigned SHARE_W         = WORD_W * WORDS_PER_SHARE;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_KEY = 2'd1,
        ST_LOAD_PT  = 2'd2,
        ST_HOLD     = 2'd3
    } state_e;

    // WORDS_PER_VEC and the counter width depend on the share count, so they are
    // derived per instance from these helpers.
    function automatic int unsigned words_per_vec(input int unsigned d);
        return WORDS_PER_SHARE * d;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned d);
        return $clog2(WORDS_PER_SHARE * d);
    endfunction

endpackage

// File: rtl/aes_shares_loader_shares_word_reg.sv
// rtl/aes_shares_loader_shares_word_reg.sv - 128*d-bit share vector register written one 32-bit word at a time
module shares_word_reg
    import aes_shares_loader_pkg::*;
#(
    parameter int unsigned D     = 2,
    parameter int unsigned IDX_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic [WORD_W-1:0]       wdata_i,
    output logic [SHARE_W*D-1:0]    q_o
);

    localparam int unsigned WORDS = WORDS_PER_SHARE * D;

    logic [SHARE_W*D-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (we_i) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx_i == IDX_W'(w)) begin
                    data_q[WORD_W*w +: WORD_W] <= wdata_i;
                end
            end
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/aes_shares_loader.sv
// rtl/aes_shares_loader.sv - assembles streamed 32-bit key/plaintext share words into full share vectors
module aes_shares_loader
    import aes_shares_loader_pkg::*;
#(
    parameter int unsigned d = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_key_reuse,
    output logic                  key_loaded,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SHARE_W*d-1:0]  out_shares_key,
    output logic [SHARE_W*d-1:0]  out_shares_plaintext
);

    localparam int unsigned WORDS_PER_VEC = words_per_vec(d);
    localparam int unsigned CNT_W         = cnt_width(d);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_VEC - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             key_loaded_q;

    logic beat;
    logic reuse_eff;
    logic last_word;
    logic key_we_d;
    logic pt_we_d;

    assign beat      = in_valid & in_ready_q;
    assign reuse_eff = in_key_reuse & key_loaded_q;
    assign last_word = (cnt_q == CNT_LAST);

    // The counter sits at 0 in IDLE, so the opening beat of a block always lands in word 0.
    assign key_we_d = beat & ((state_q == ST_LOAD_KEY) | ((state_q == ST_IDLE) & ~reuse_eff));
    assign pt_we_d  = beat & ((state_q == ST_LOAD_PT)  | ((state_q == ST_IDLE) &  reuse_eff));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (beat) begin
                        cnt_q <= CNT_W'(1);
                        if (reuse_eff) begin
                            state_q <= ST_LOAD_PT;
                        end else begin
                            state_q      <= ST_LOAD_KEY;
                            key_loaded_q <= 1'b0;
                        end
                    end
                end
                ST_LOAD_KEY: begin
                    if (beat) begin
                        if (last_word) begin
                            state_q      <= ST_LOAD_PT;
                            cnt_q        <= '0;
                            key_loaded_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_PT: begin
                    if (beat) begin
                        if (last_word) begin
                            state_q     <= ST_HOLD;
                            cnt_q       <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid_q & out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    shares_word_reg #(
        .D     (d),
        .IDX_W (CNT_W)
    ) u_key_reg (
        .clk     (clk),
        .rst     (rst),
        .we_i    (key_we_d),
        .idx_i   (cnt_q),
        .wdata_i (in_data),
        .q_o     (out_shares_key)
    );

    shares_word_reg #(
        .D     (d),
        .IDX_W (CNT_W)
    ) u_pt_reg (
        .clk     (clk),
        .rst     (rst),
        .we_i    (pt_we_d),
        .idx_i   (cnt_q),
        .wdata_i (in_data),
        .q_o     (out_shares_plaintext)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign key_loaded = key_loaded_q;

endmodule
